// File: rtl/pipe_if_stage_pkg.sv
// Shared encodings for the pipelined-CPU instruction-fetch stage.
// Holds the next-PC select codes, the fetch FSM states and fixed widths.
package pipe_if_stage_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PCS_W  = 2;
    localparam int unsigned ST_W   = 2;

    typedef enum logic [PCS_W-1:0] {
        PCS_SEQ = 2'b00,
        PCS_BR  = 2'b01,
        PCS_JR  = 2'b10,
        PCS_J   = 2'b11
    } pcsource_e;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } if_state_e;

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC selection: redirect target select, then redirect / pending / sequential priority.
// Purely combinational; the IF stage registers the result on an accept.
module pipe_npc_mux
    import pipe_if_stage_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [PCS_W-1:0] pcsource,
    input  logic [AW-1:0]    bpc,
    input  logic [AW-1:0]    da,
    input  logic [AW-1:0]    jpc,
    input  logic [AW-1:0]    pc,
    input  logic             redirect,
    input  logic             pend,
    input  logic [AW-1:0]    pend_tgt,
    output logic [AW-1:0]    target_c,
    output logic [AW-1:0]    pc_plus4_c,
    output logic [AW-1:0]    npc_c
);

    // Redirect target chosen by the ID instruction's pcsource
    always_comb begin
        target_c = bpc;
        case (pcsource_e'(pcsource))
            PCS_BR:  target_c = bpc;
            PCS_JR:  target_c = da;
            PCS_J:   target_c = jpc;
            default: target_c = bpc;
        endcase
    end

    // Same-cycle redirect beats a parked one; otherwise fall through sequentially
    always_comb begin
        pc_plus4_c = pc + AW'(4);
        npc_c      = pc_plus4_c;
        if (redirect) begin
            npc_c = target_c;
        end else if (pend) begin
            npc_c = pend_tgt;
        end
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction fetch stage with IF/ID register for the 5-stage pipeline.
// Req/ack fetch from variable-latency memory, one branch delay slot.
module pipe_if_stage
    import pipe_if_stage_pkg::*;
#(
    parameter int unsigned    AW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wpcir,
    input  logic [PCS_W-1:0]  pcsource,
    input  logic [AW-1:0]     bpc,
    input  logic [AW-1:0]     da,
    input  logic [AW-1:0]     jpc,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [AW-1:0]     pc,
    output logic [AW-1:0]     dpc4,
    output logic [INST_W-1:0] dinst,
    output logic              dvalid
);

    if_state_e         state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [AW-1:0]     dpc4_q, dpc4_d;
    logic [INST_W-1:0] dinst_q, dinst_d;
    logic              dvalid_q, dvalid_d;
    logic [INST_W-1:0] buf_q, buf_d;
    logic              pend_q, pend_d;
    logic [AW-1:0]     pend_tgt_q, pend_tgt_d;
    logic              imem_req_q, imem_req_d;

    logic              fetch_ack_c;
    logic              accept_c;
    logic              redirect_c;
    logic [AW-1:0]     target_c;
    logic [AW-1:0]     pc_plus4_c;
    logic [AW-1:0]     npc_c;

    // Ack only counts while a request is actually outstanding
    assign fetch_ack_c = (state_q == ST_FETCH) && imem_ack;
    assign accept_c    = wpcir && (fetch_ack_c || (state_q == ST_HOLD));
    assign redirect_c  = dvalid_q && wpcir && (pcsource != PCS_SEQ);

    pipe_npc_mux #(
        .AW (AW)
    ) u_npc_mux (
        .pcsource   (pcsource),
        .bpc        (bpc),
        .da         (da),
        .jpc        (jpc),
        .pc         (pc_q),
        .redirect   (redirect_c),
        .pend       (pend_q),
        .pend_tgt   (pend_tgt_q),
        .target_c   (target_c),
        .pc_plus4_c (pc_plus4_c),
        .npc_c      (npc_c)
    );

    // State register and datapath flops
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            dpc4_q     <= '0;
            dinst_q    <= '0;
            dvalid_q   <= 1'b0;
            buf_q      <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dpc4_q     <= dpc4_d;
            dinst_q    <= dinst_d;
            dvalid_q   <= dvalid_d;
            buf_q      <= buf_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            imem_req_q <= imem_req_d;
        end
    end

    // Fetch FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (fetch_ack_c && !wpcir) state_d = ST_HOLD;
            ST_HOLD:  if (wpcir) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // IF/ID load, PC update, stall buffer and pending redirect
    always_comb begin
        pc_d       = pc_q;
        dpc4_d     = dpc4_q;
        dinst_d    = dinst_q;
        dvalid_d   = dvalid_q;
        buf_d      = buf_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        imem_req_d = (state_d == ST_FETCH);

        if (accept_c) begin
            dinst_d  = (state_q == ST_HOLD) ? buf_q : imem_rdata;
            dpc4_d   = pc_plus4_c;
            dvalid_d = 1'b1;
            pc_d     = npc_c;
            pend_d   = 1'b0;
        end else begin
            if (wpcir) begin
                dvalid_d = 1'b0;
                dinst_d  = '0;
            end
            if (fetch_ack_c) begin
                buf_d = imem_rdata;
            end
            // Park the target so the delay slot is still fetched first
            if (redirect_c) begin
                pend_d     = 1'b1;
                pend_tgt_d = target_c;
            end
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dpc4      = dpc4_q;
    assign dinst     = dinst_q;
    assign dvalid    = dvalid_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Randomized bench for pipe_if_stage: a program-order model predicts every
// instruction entering IF/ID from memory contents and delay-slot redirect rules.
module tb_pipe_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wpcir = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0, da = '0, jpc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc, dpc4, dinst;
    logic        dvalid;

    pipe_if_stage #(
        .AW       (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .da         (da),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .dpc4       (dpc4),
        .dinst      (dinst),
        .dvalid     (dvalid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model and stimulus knobs
    bit          outstanding = 1'b0;
    int          lat_cnt = 0;
    int          lat_min = 0, lat_max = 0;
    int          stall_pct = 0;
    bit          redir_en = 1'b0;

    // program-order reference: next instruction address expected in ID
    logic [31:0] exp_addr = RESET_PC;
    bit          armed = 1'b0;
    logic [31:0] armed_tgt = '0;
    int          accepted = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [7:0] w;
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF8;
        w = 8'($urandom_range(0, 255));
        return {22'h0, w, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, check against the model after posedge
    task automatic step(input bit rst_in, input bit force_ack);
        bit          p_req, p_ack, p_wp, p_valid, redir;
        logic [31:0] p_addr, p_dinst, p_dpc4, tgt;
        @(negedge clock);
        imem_ack = 1'b0;
        if (force_ack) begin
            imem_ack = 1'b1;
        end else if (imem_req) begin
            if (!outstanding) begin
                outstanding = 1'b1;
                lat_cnt = $urandom_range(lat_min, lat_max);
            end
            if (lat_cnt == 0) begin
                imem_ack = 1'b1;
                outstanding = 1'b0;
            end else begin
                lat_cnt--;
            end
        end
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
        wpcir    = ($urandom_range(0, 99) >= stall_pct);
        pcsource = redir_en ? 2'($urandom_range(0, 3)) : 2'b00;
        bpc = rand_tgt();
        da  = rand_tgt();
        jpc = rand_tgt();
        reset = rst_in;
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
        p_wp = wpcir; p_valid = dvalid; p_dinst = dinst; p_dpc4 = dpc4;
        tgt = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? da : jpc;
        @(posedge clock);
        #1;
        if (rst_in) begin
            outstanding = 1'b0;
            exp_addr = RESET_PC;
            armed = 1'b0;
            return;
        end
        if (p_req && !p_ack) begin
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, p_addr);
        end
        if (p_req && p_ack && !p_wp) chk("hold_no_req", {31'b0, imem_req}, 32'd0);
        redir = p_valid && p_wp && (pcsource != 2'b00);
        if (redir) begin
            chk("no_redirect_while_pending", {31'b0, armed}, 32'd0);
            armed = 1'b1;
            armed_tgt = tgt;
        end
        if (p_wp) begin
            if (dvalid) begin
                chk("dinst", dinst, mem_word(exp_addr));
                chk("dpc4", dpc4, exp_addr + 32'd4);
                exp_addr = armed ? armed_tgt : exp_addr + 32'd4;
                armed = 1'b0;
                accepted++;
            end else begin
                chk("bubble_dinst", dinst, 32'd0);
                chk("bubble_dpc4", dpc4, p_dpc4);
            end
        end else begin
            chk("stall_dvalid", {31'b0, dvalid}, {31'b0, p_valid});
            chk("stall_dinst", dinst, p_dinst);
            chk("stall_dpc4", dpc4, p_dpc4);
        end
        if (armed) chk("pending_id_bubble", {31'b0, dvalid}, 32'd0);
    endtask

    task automatic chk_reset_state();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_dvalid", {31'b0, dvalid}, 32'd0);
        chk("rst_dinst", dinst, 32'd0);
        chk("rst_dpc4", dpc4, 32'd0);
    endtask

    initial begin
        bit seen;

        // reset
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk_reset_state();

        // zero-wait, no stalls: one fetch per cycle, addresses 0,4,8,...
        lat_min = 0; lat_max = 0; stall_pct = 0; redir_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            chk("seq_req", {31'b0, imem_req}, 32'd1);
            chk("seq_addr", imem_addr, RESET_PC + 32'(4 * i));
        end
        chk("seq_dpc4", dpc4, RESET_PC + 32'd20);

        // fixed 3-cycle memory: request held, bubbles between words
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0);

        // stalls with immediate memory exercise the HOLD buffer
        lat_min = 0; lat_max = 1; stall_pct = 50;
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0);

        // everything random: latency, stalls, branches / jr / j
        lat_min = 0; lat_max = 3; stall_pct = 30; redir_en = 1'b1;
        for (int i = 0; i < 3000; i++) step(1'b0, 1'b0);

        // reset while a fetch is outstanding, with a late ack in the reset cycle
        lat_min = 5; lat_max = 5; stall_pct = 0; redir_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 1'b0);
            seen = imem_req && outstanding;
        end
        chk("fetch_outstanding_seen", {31'b0, seen}, 32'd1);
        step(1'b1, 1'b1);
        chk_reset_state();
        lat_min = 0; lat_max = 0;
        step(1'b0, 1'b0);
        chk("post_rst_req", {31'b0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("post_rst_dpc4", dpc4, RESET_PC + 32'd32);

        chk("progress", {31'b0, accepted > 500}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
